ssd1306_i2c_responder: RTL and testbench

- I2C target (write-only) modelling the SSD1306 end of the display bus; decodes the frames issued by the OLED driver FSM and its I2C master.
- Oversamples SCL/SDA on the system clock, ACKs its address, parses SSD1306 control bytes (Co, D/C#), and emits each command or GDDRAM data byte as a one-cycle strobe.
- Used as a display stand-in on-chip and as the checking end in driver benches.

---
 rtl/ssd1306_pkg.sv | 34 +++
 rtl/i2c_line_sync.sv | 58 +++++
 rtl/ssd1306_i2c_responder.sv | 176 +++++++++++++++++
 tb/tb_ssd1306_i2c_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd1306_pkg.sv
// ----------------------------------------------------------------------------
// ssd1306_pkg
// Shared definitions for the SSD1306 I2C responder and the OLED driver:
//   state_t              responder FSM states
//   CTRL_CO_BIT/DC_BIT   bit positions inside an SSD1306 control byte
//   SSD1306_ADDR_DEFAULT 7-bit bus address of the panel
//   CMD_*                command opcodes issued by the driver
// ----------------------------------------------------------------------------
package ssd1306_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_CTRL,
      ST_CTRL_ACK,
      ST_PAYLOAD,
      ST_PAY_ACK,
      ST_IGNORE
   } state_t;

   localparam int CTRL_CO_BIT = 7;
   localparam int CTRL_DC_BIT = 6;

   localparam logic [6:0] SSD1306_ADDR_DEFAULT = 7'h3C;

   localparam logic [7:0] CMD_DISPLAY_OFF   = 8'hAE;
   localparam logic [7:0] CMD_DISPLAY_ON    = 8'hAF;
   localparam logic [7:0] CMD_RESUME_RAM    = 8'hA4;
   localparam logic [7:0] CMD_ENTIRE_ON     = 8'hA5;
   localparam logic [7:0] CMD_CHARGE_PUMP   = 8'h8D;
   localparam logic [7:0] CMD_ADDR_MODE     = 8'h20;

endpackage

// File: rtl/i2c_line_sync.sv
// ----------------------------------------------------------------------------
// i2c_line_sync
// Brings SCL/SDA into the clk domain and derives bus events.
//   clk, rst            system clock, asynchronous active-high reset
//   scl, sda            raw bus levels
//   scl_s, sda_s        synchronised levels
//   scl_rise, scl_fall  one-cycle pulses on synchronised SCL edges
//   start_det           SDA fell while SCL stayed high
//   stop_det            SDA rose while SCL stayed high
// SYNC_STAGES must be at least 2.
// ----------------------------------------------------------------------------
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl,
   input  logic sda,
   output logic scl_s,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_pipe_reg;
   logic [SYNC_STAGES-1:0] sda_pipe_reg;
   logic                   scl_d_reg;
   logic                   sda_d_reg;

   // Pipes reset to the idle bus level (high) so leaving reset never
   // fabricates a START or STOP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_pipe_reg <= '1;
         sda_pipe_reg <= '1;
         scl_d_reg    <= 1'b1;
         sda_d_reg    <= 1'b1;
      end else begin
         scl_pipe_reg <= {scl_pipe_reg[SYNC_STAGES-2:0], scl};
         sda_pipe_reg <= {sda_pipe_reg[SYNC_STAGES-2:0], sda};
         scl_d_reg    <= scl_s;
         sda_d_reg    <= sda_s;
      end
   end

   assign scl_s    = scl_pipe_reg[SYNC_STAGES-1];
   assign sda_s    = sda_pipe_reg[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_d_reg;
   assign scl_fall = ~scl_s & scl_d_reg;

   // SCL must be high on both sides of the SDA edge; an SDA edge that lands
   // together with an SCL edge is a data change, not a bus condition.
   assign start_det = scl_s & scl_d_reg & sda_d_reg & ~sda_s;
   assign stop_det  = scl_s & scl_d_reg & ~sda_d_reg & sda_s;

endmodule

// File: rtl/ssd1306_i2c_responder.sv
// ----------------------------------------------------------------------------
// ssd1306_i2c_responder
// Write-only I2C target standing in for an SSD1306 panel. ACKs ADDR, parses
// control bytes (Co, D/C#) and strobes out each command / GDDRAM byte.
//   clk, rst      system clock, asynchronous active-high reset
//   scl, sda_i    bus clock and sampled SDA level
//   sda_oe        1 = pull SDA low (ACK)
//   byte_valid    one-cycle strobe, byte_out/byte_is_data valid
//   byte_out      payload byte, byte_is_data = 1 for GDDRAM data
//   frame_start   pulse on matching write address
//   frame_end     pulse on STOP / repeated START closing a matched frame
//   busy          matched frame in progress
//   proto_err     sticky: frame without control byte, or control bits[5:0]!=0
// ----------------------------------------------------------------------------
module ssd1306_i2c_responder
   import ssd1306_pkg::*;
#(
   parameter logic [6:0] ADDR        = SSD1306_ADDR_DEFAULT,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic       byte_valid,
   output logic [7:0] byte_out,
   output logic       byte_is_data,
   output logic       frame_start,
   output logic       frame_end,
   output logic       busy,
   output logic       proto_err
);

   logic   scl_sync, sda_sync, scl_rise, scl_fall, start_det, stop_det;
   state_t state_reg, state_next;
   logic [3:0] bit_cnt_reg;
   logic [6:0] shift_reg;
   logic       ack_on_reg, co_reg, dc_reg, ctrl_seen_reg;
   logic       busy_reg, proto_err_reg, byte_valid_reg, byte_is_data_reg;
   logic       frame_start_reg, frame_end_reg;
   logic [7:0] byte_out_reg;
   logic       busy_next, proto_err_next, byte_valid_next;
   logic       frame_start_next, frame_end_next;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst       (rst),
      .scl       (scl),
      .sda       (sda_i),
      .scl_s     (scl_sync),
      .sda_s     (sda_sync),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   logic       bus_evt, bit_sample, in_byte, ack_state, byte_done, ack_end, addr_hit;
   logic [7:0] shifted;

   assign bus_evt    = start_det | stop_det;
   assign bit_sample = scl_rise & scl_sync;
   assign shifted    = {shift_reg, sda_sync};
   assign in_byte    = (state_reg == ST_ADDR) || (state_reg == ST_CTRL) ||
                       (state_reg == ST_PAYLOAD);
   assign ack_state  = (state_reg == ST_ADDR_ACK) || (state_reg == ST_CTRL_ACK) ||
                       (state_reg == ST_PAY_ACK);
   assign byte_done  = in_byte && bit_sample && (bit_cnt_reg == 4'd7);
   // Second SCL fall inside an ACK state closes the 9th clock.
   assign ack_end    = ack_state && scl_fall && ack_on_reg;
   assign addr_hit   = (shifted[7:1] == ADDR) && !shifted[0];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   // Next-state logic; STOP outranks START, both outrank byte progress.
   always_comb begin
      state_next = state_reg;
      if (stop_det) begin
         state_next = ST_IDLE;
      end else if (start_det) begin
         state_next = ST_ADDR;
      end else begin
         case (state_reg)
            ST_ADDR:     if (byte_done) state_next = addr_hit ? ST_ADDR_ACK : ST_IGNORE;
            ST_CTRL:     if (byte_done) state_next = ST_CTRL_ACK;
            ST_PAYLOAD:  if (byte_done) state_next = ST_PAY_ACK;
            ST_ADDR_ACK: if (ack_end)   state_next = ST_CTRL;
            ST_CTRL_ACK: if (ack_end)   state_next = ST_PAYLOAD;
            ST_PAY_ACK:  if (ack_end)   state_next = co_reg ? ST_CTRL : ST_PAYLOAD;
            default:     state_next = state_reg;
         endcase
      end
   end

   // Output logic (next values of the registered outputs, plus sda_oe)
   always_comb begin
      frame_start_next = (state_reg == ST_ADDR) && byte_done && addr_hit && !bus_evt;
      frame_end_next   = busy_reg && bus_evt;
      byte_valid_next  = (state_reg == ST_PAYLOAD) && byte_done && !bus_evt;
      busy_next        = busy_reg;
      if (frame_start_next) busy_next = 1'b1;
      else if (bus_evt)     busy_next = 1'b0;
      proto_err_next = proto_err_reg;
      // Frame closed before its first control byte completed.
      if (bus_evt && !ctrl_seen_reg &&
          ((state_reg == ST_ADDR_ACK) || (state_reg == ST_CTRL)))
         proto_err_next = 1'b1;
      if ((state_reg == ST_CTRL) && byte_done && !bus_evt && (shifted[5:0] != 6'd0))
         proto_err_next = 1'b1;
      // Released combinationally so a STOP frees the line in its own cycle.
      sda_oe = ack_on_reg && !bus_evt;
   end

   // Datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_reg      <= 4'd0;
         shift_reg        <= 7'd0;
         ack_on_reg       <= 1'b0;
         co_reg           <= 1'b0;
         dc_reg           <= 1'b0;
         ctrl_seen_reg    <= 1'b0;
         busy_reg         <= 1'b0;
         proto_err_reg    <= 1'b0;
         byte_valid_reg   <= 1'b0;
         byte_out_reg     <= 8'd0;
         byte_is_data_reg <= 1'b0;
         frame_start_reg  <= 1'b0;
         frame_end_reg    <= 1'b0;
      end else begin
         busy_reg        <= busy_next;
         proto_err_reg   <= proto_err_next;
         byte_valid_reg  <= byte_valid_next;
         frame_start_reg <= frame_start_next;
         frame_end_reg   <= frame_end_next;

         if (byte_valid_next) begin
            byte_out_reg     <= shifted;
            byte_is_data_reg <= dc_reg;
         end

         // Counter saturates at 8; it restarts in every non-byte state.
         if (bus_evt || !in_byte) begin
            bit_cnt_reg <= 4'd0;
         end else if (bit_sample) begin
            shift_reg <= shifted[6:0];
            if (bit_cnt_reg != 4'd8) bit_cnt_reg <= bit_cnt_reg + 4'd1;
         end

         // First fall in an ACK state starts driving, the second ends it.
         if (bus_evt || !ack_state) ack_on_reg <= 1'b0;
         else if (scl_fall)         ack_on_reg <= ~ack_on_reg;

         if (frame_start_next || bus_evt) ctrl_seen_reg <= 1'b0;
         if ((state_reg == ST_CTRL) && byte_done && !bus_evt) begin
            co_reg        <= shifted[CTRL_CO_BIT];
            dc_reg        <= shifted[CTRL_DC_BIT];
            ctrl_seen_reg <= 1'b1;
         end
      end
   end

   assign byte_valid   = byte_valid_reg;
   assign byte_out     = byte_out_reg;
   assign byte_is_data = byte_is_data_reg;
   assign frame_start  = frame_start_reg;
   assign frame_end    = frame_end_reg;
   assign busy         = busy_reg;
   assign proto_err    = proto_err_reg;

endmodule

// File: tb/tb_ssd1306_i2c_responder.sv
// ----------------------------------------------------------------------------
// tb_ssd1306_i2c_responder
// Bit-bangs I2C frames into the responder; expected payload strobes are
// queued as bytes are sent and popped when byte_valid fires.
// ----------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_ssd1306_i2c_responder;
   import ssd1306_pkg::*;

   localparam time Q = 50;   // quarter SCL period (5 clk cycles)

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       sda_drv = 1'b1;
   logic       sda_i;
   logic       sda_oe, byte_valid, byte_is_data, frame_start, frame_end, busy, proto_err;
   logic [7:0] byte_out;

   // Open-drain bus: low if either side pulls.
   assign sda_i = sda_drv & ~sda_oe;

   always #5 clk = ~clk;

   ssd1306_i2c_responder dut (
      .clk          (clk),
      .rst          (rst),
      .scl          (scl),
      .sda_i        (sda_i),
      .sda_oe       (sda_oe),
      .byte_valid   (byte_valid),
      .byte_out     (byte_out),
      .byte_is_data (byte_is_data),
      .frame_start  (frame_start),
      .frame_end    (frame_end),
      .busy         (busy),
      .proto_err    (proto_err)
   );

   int         checks = 0;
   int         errors = 0;
   int         fs_cnt = 0;
   int         fe_cnt = 0;
   int         str_cnt = 0;
   logic       oe_seen = 1'b0;
   logic [8:0] exp_q[$];
   logic [8:0] mon_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end else begin
         $display("ok   %s value=%0h", name, act);
      end
   endtask

   // Scoreboard / event monitor, sampled on the falling clock edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_start) fs_cnt++;
         if (frame_end)   fe_cnt++;
         if (sda_oe)      oe_seen = 1'b1;
         if (byte_valid) begin
            str_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL strobe_unexpected actual=%0h required=none", {byte_is_data, byte_out});
            end else begin
               mon_exp = exp_q.pop_front();
               check("strobe", {23'd0, byte_is_data, byte_out}, {23'd0, mon_exp});
            end
         end
      end
   end

   task automatic bit_clk(input logic b);
      sda_drv = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic acked);
      for (int i = 7; i >= 0; i--) bit_clk(b[i]);
      sda_drv = 1'b1; #Q; scl = 1'b1; #Q;
      acked = ~sda_i;
      #Q; scl = 1'b0; #Q;
   endtask

   task automatic send_chk(input logic [7:0] b, input logic exp_ack, input string name);
      logic a;
      send_byte(b, a);
      check(name, {31'd0, a}, {31'd0, exp_ack});
   endtask

   task automatic i2c_start;
      sda_drv = 1'b1; #Q; scl = 1'b1; #Q; sda_drv = 1'b0; #Q; scl = 1'b0; #Q;
   endtask

   task automatic i2c_stop;
      sda_drv = 1'b0; #Q; scl = 1'b1; #Q; sda_drv = 1'b1; #(2*Q);
   endtask

   task automatic reset_dut;
      rst = 1'b1; #20; rst = 1'b0; #20;
   endtask

   typedef struct {
      logic [7:0] addr;
      logic [7:0] ctrl;
      logic [7:0] pay;
      logic       exp_ack;
      logic       exp_dc;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int fs0, fe0, st0;
      logic a;

      vecs[0] = '{8'h78, 8'h00, CMD_DISPLAY_OFF, 1'b1, 1'b0};
      vecs[1] = '{8'h78, 8'h40, 8'h5A,           1'b1, 1'b1};
      vecs[2] = '{8'h7A, 8'h00, 8'h11,           1'b0, 1'b0};
      vecs[3] = '{8'h79, 8'h00, 8'h22,           1'b0, 1'b0};
      vecs[4] = '{8'h78, 8'h80, CMD_RESUME_RAM,  1'b1, 1'b0};
      vecs[5] = '{8'h78, 8'hC0, CMD_ADDR_MODE,   1'b1, 1'b1};

      #7;   // keep every stimulus change off the clock edges
      check("reset_outputs", {19'd0, sda_oe, byte_valid, byte_out, byte_is_data,
            frame_start, frame_end, busy, proto_err}, 32'd0);
      rst = 1'b0; #40;
      check("idle_outputs", {19'd0, sda_oe, byte_valid, byte_out, byte_is_data,
            frame_start, frame_end, busy, proto_err}, 32'd0);

      // Single-payload frames from the table.
      for (int v = 0; v < 6; v++) begin
         fs0 = fs_cnt; fe0 = fe_cnt; oe_seen = 1'b0;
         $display("vector %0d addr=%0h ctrl=%0h pay=%0h", v, vecs[v].addr, vecs[v].ctrl, vecs[v].pay);
         i2c_start;
         send_chk(vecs[v].addr, vecs[v].exp_ack, "addr_ack");
         if (vecs[v].exp_ack) begin
            send_chk(vecs[v].ctrl, 1'b1, "ctrl_ack");
            exp_q.push_back({vecs[v].exp_dc, vecs[v].pay});
            send_chk(vecs[v].pay, 1'b1, "pay_ack");
         end
         check("busy_in_frame", {31'd0, busy}, {31'd0, vecs[v].exp_ack});
         i2c_stop;
         #(4*Q);
         check("frame_start_cnt", fs_cnt - fs0, {31'd0, vecs[v].exp_ack});
         check("frame_end_cnt", fe_cnt - fe0, {31'd0, vecs[v].exp_ack});
         check("oe_seen", {31'd0, oe_seen}, {31'd0, vecs[v].exp_ack});
         check("busy_after", {31'd0, busy}, 32'd0);
         check("queue_drained", exp_q.size(), 32'd0);
      end
      check("no_proto_err", {31'd0, proto_err}, 32'd0);

      // 128 GDDRAM bytes in one Co=0 data frame.
      $display("sequence gddram_128");
      st0 = str_cnt;
      i2c_start;
      send_chk(8'h78, 1'b1, "g_addr_ack");
      send_chk(8'h40, 1'b1, "g_ctrl_ack");
      for (int i = 0; i < 128; i++) begin
         exp_q.push_back({1'b1, 8'h00});
         send_byte(8'h00, a);
         check("g_ack_busy", {30'd0, a, busy}, 32'd3);
      end
      i2c_stop;
      #(4*Q);
      check("g_strobe_cnt", str_cnt - st0, 32'd128);

      // Co=1 pairs: command then data.
      $display("sequence co1_pairs");
      i2c_start;
      send_chk(8'h78, 1'b1, "c_addr_ack");
      send_chk(8'h80, 1'b1, "c_ctrl1_ack");
      exp_q.push_back({1'b0, CMD_ENTIRE_ON});
      send_chk(CMD_ENTIRE_ON, 1'b1, "c_pay1_ack");
      send_chk(8'hC0, 1'b1, "c_ctrl2_ack");
      exp_q.push_back({1'b1, 8'hFF});
      send_chk(8'hFF, 1'b1, "c_pay2_ack");
      i2c_stop;
      #(4*Q);
      check("c_queue_drained", exp_q.size(), 32'd0);
      check("c_no_proto_err", {31'd0, proto_err}, 32'd0);

      // Repeated START after 4 payload bits.
      $display("sequence repeated_start");
      i2c_start;
      send_chk(8'h78, 1'b1, "r_addr_ack");
      send_chk(8'h00, 1'b1, "r_ctrl_ack");
      bit_clk(1'b1); bit_clk(1'b0); bit_clk(1'b1); bit_clk(1'b0);
      fe0 = fe_cnt; st0 = str_cnt;
      i2c_start;
      #(2*Q);
      check("r_frame_end_at_start", fe_cnt - fe0, 32'd1);
      check("r_busy_cleared", {31'd0, busy}, 32'd0);
      send_chk(8'h78, 1'b1, "r_addr2_ack");
      send_chk(8'h00, 1'b1, "r_ctrl2_ack");
      exp_q.push_back({1'b0, CMD_DISPLAY_ON});
      send_chk(CMD_DISPLAY_ON, 1'b1, "r_pay_ack");
      i2c_stop;
      #(4*Q);
      check("r_one_strobe", str_cnt - st0, 32'd1);
      check("r_no_proto_err", {31'd0, proto_err}, 32'd0);

      // Protocol errors.
      $display("sequence proto_no_ctrl");
      i2c_start;
      send_chk(8'h78, 1'b1, "p_addr_ack");
      i2c_stop;
      #(4*Q);
      check("p_err_no_ctrl", {31'd0, proto_err}, 32'd1);
      reset_dut;
      check("p_err_cleared", {31'd0, proto_err}, 32'd0);
      $display("sequence proto_ctrl_05");
      i2c_start;
      send_chk(8'h78, 1'b1, "p2_addr_ack");
      send_chk(8'h05, 1'b1, "p2_ctrl_ack");
      exp_q.push_back({1'b0, 8'h11});
      send_chk(8'h11, 1'b1, "p2_pay_ack");
      i2c_stop;
      #(4*Q);
      check("p2_err_ctrl_bits", {31'd0, proto_err}, 32'd1);
      check("p2_queue_drained", exp_q.size(), 32'd0);
      reset_dut;

      // Asynchronous reset while the address ACK is driven.
      $display("sequence rst_mid_ack");
      i2c_start;
      for (int i = 7; i >= 0; i--) bit_clk(((8'h78 >> i) & 8'h01) != 8'h00);
      check("m_ack_driven", {31'd0, sda_oe}, 32'd1);
      #1 rst = 1'b1;
      #1 check("m_rst_async_oe", {31'd0, sda_oe}, 32'd0);
      #18 rst = 1'b0;
      #10;
      check("m_idle_after_rst", {30'd0, busy, proto_err}, 32'd0);
      i2c_stop;
      fs0 = fs_cnt;
      i2c_start;
      send_chk(8'h78, 1'b1, "m_addr_ack");
      send_chk(8'h00, 1'b1, "m_ctrl_ack");
      exp_q.push_back({1'b0, CMD_DISPLAY_ON});
      send_chk(CMD_DISPLAY_ON, 1'b1, "m_pay_ack");
      i2c_stop;
      #(4*Q);
      check("m_recovered_frame", fs_cnt - fs0, 32'd1);
      check("m_queue_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
